// File: rtl/slice_subtractor.sv
// slice_subtractor: multi-cycle 32-bit a-b via a+~b+1, one 4-bit CLA slice per clock; SLICE_SUB_OVF_EN enables signed overflow
module slice_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        valid,
    output logic [31:0] diff,
    output logic        borrow_out,
    output logic        zero,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      r_state;
    logic [31:0] r_a, r_nb, r_acc, r_diff;
    logic [2:0]  r_cnt;
    logic        r_carry, r_borrow, r_zero;
    logic [3:0]  w_g, w_p, w_sum;
    logic [4:0]  w_c;
    logic [31:0] w_acc_next;

    assign w_g = r_a[{r_cnt, 2'b00} +: 4] & r_nb[{r_cnt, 2'b00} +: 4];
    assign w_p = r_a[{r_cnt, 2'b00} +: 4] ^ r_nb[{r_cnt, 2'b00} +: 4];
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                  | (&w_p & w_c[0]);
    assign w_sum = w_p ^ w_c[3:0];

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_cnt, 2'b00} +: 4] = w_sum;
    end

    assign ready      = (r_state == IDLE);
    assign valid      = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign zero       = r_zero;

`ifdef SLICE_SUB_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_nb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
`ifdef SLICE_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_nb    <= ~b;
                    r_cnt   <= '0;
                    r_carry <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_c[4];
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state  <= DONE;
                        r_diff   <= w_acc_next;
                        r_borrow <= ~w_c[4];
                        r_zero   <= (w_acc_next == '0);
`ifdef SLICE_SUB_OVF_EN
                        // operands differ in sign and the result sign departs from the minuend
                        r_ovf    <= (r_a[31] != ~r_nb[31]) && (w_acc_next[31] != r_a[31]);
`endif
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
